// File: rtl/mac_accumulator.sv
// mac_accumulator
//
// Accumulation stage that sits behind the combinational mac unit. A frame is
// opened with a start pulse carrying a term count. Each accepted beat adds the
// unsigned 32-bit mac result to a wide accumulator. The accumulator saturates
// at all-ones instead of wrapping. Once the programmed number of terms has been
// accepted, the total is offered downstream on a valid/ready handshake.
//
// Ports
//   clk        in   single rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   frame start pulse, only looked at while idle
//   len        in   number of terms in the frame (CNT_W bits), sampled with start
//   in_valid   in   r_in carries a valid mac result
//   in_ready   out  a beat on r_in is accepted this cycle
//   r_in       in   32-bit unsigned mac result
//   out_valid  out  acc_out holds the final frame sum
//   out_ready  in   downstream takes acc_out
//   acc_out    out  accumulator value (ACC_W bits, unsigned)
//   overflow   out  the frame saturated; meaningful while out_valid is high
//   busy       out  a frame is in progress or waiting to be delivered
//
// Parameters
//   ACC_W  accumulator width, at least 33 so that one term never saturates
//   CNT_W  term count width; frames hold up to 2**CNT_W - 1 terms

module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;

    // One extra bit above the accumulator catches the carry that signals
    // saturation; r_in is zero-extended up to that width.
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] next_count;
    logic             accept;
    logic             last_beat;

    // Beat acceptance and the widened sum used for the saturation decision.
    always_comb begin
        sum        = {1'b0, acc} + {{(ACC_W-31){1'b0}}, r_in};
        next_count = count + 1'b1;
        accept     = in_valid & in_ready;
        last_beat  = (next_count == len_q);
    end

    assign acc_out = acc;

    // Frame FSM. in_ready, out_valid and busy are registered alongside the
    // state so they are clean state decodes with no path from in_valid or
    // out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            len_q    <= len;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            // An empty frame goes straight to delivery with a zero sum.
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        count <= next_count;
                        // Once saturated, the accumulator stays pinned at all-ones
                        // even if a later term happens to be zero.
                        if (sum[ACC_W] || overflow) begin
                            acc      <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        if (last_beat) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulation stage directly downstream of the combinational `mac` unit. Consumes one 32-bit unsigned `mac` result `R` per accepted beat and sums a programmed number of terms into a wide saturating accumulator. Delivers the total over a valid/ready output handshake. Turns the single-shot MAC datapath into a length-N dot-product engine without changing the arithmetic core.

## Interface
Parameters:
- `ACC_W`, 40: accumulator and result width; must be ≥ 33.
- `CNT_W`, 8: width of the term-count field. Maximum frame length is 2^CNT_W − 1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: frame start pulse; sampled only in IDLE.
- `len` in CNT_W: number of terms in the frame; sampled with `start`.
- `in_valid` in 1: `r_in` carries a valid `mac` result.
- `in_ready` out 1: block accepts `r_in` this cycle.
- `r_in` in 32: unsigned `R` output of `mac`.
- `out_valid` out 1: `acc_out` holds the final frame sum.
- `out_ready` in 1: downstream accepts `acc_out`.
- `acc_out` out ACC_W: accumulated sum, unsigned.
- `overflow` out 1: the frame saturated; valid while `out_valid` is high.
- `busy` out 1: high in ACCUM and DONE.

## Operation
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - `in_ready` = 0.
  - `start` = 1 with `len` ≠ 0: latch `len`, clear acc, count and `overflow`, then go to ACCUM.
  - `start` = 1 with `len` = 0: clear acc and `overflow`, then go straight to DONE. The result is 0.
- ACCUM:
  - `in_ready` = 1.
  - A beat is accepted when `in_valid & in_ready`. On each beat, acc ← acc + zero-extend(`r_in`), and count increments.
  - Cycles with `in_valid` low leave acc and count unchanged.
  - The accept that brings count to the latched `len` moves the FSM to DONE.
- Saturation:
  - If the ACC_W+1-bit sum exceeds 2^ACC_W − 1, acc is set to all-ones and `overflow` is set.
  - `overflow` is sticky for the rest of the frame.
  - Later beats still count but leave acc at all-ones.
- DONE:
  - `out_valid` = 1, `in_ready` = 0.
  - `acc_out` and `overflow` are held stable.
  - On `out_valid & out_ready`, go to IDLE.
- `start` is ignored in ACCUM and DONE. It does not restart, abort or queue a frame.
- `acc_out` always reflects the acc register. Only its value while `out_valid` is high is defined as the result.

## Timing
- Reset values (after any clock edge with `rst_n` = 0):
  - State is IDLE.
  - acc = 0, count = 0.
  - `in_ready` = 0, `out_valid` = 0, `acc_out` = 0, `overflow` = 0, `busy` = 0.
- Reset during ACCUM or DONE discards the frame. The first cycle after release is IDLE.
- Latencies:
  - `start` edge to first possible accept: 1 cycle, because `in_ready` rises the cycle after `start` is sampled.
  - `len` = 0: `out_valid` rises the cycle after `start`.
  - Last accept to `out_valid`: rises on the next cycle, with the final sum present.
- Throughput is 1 term per cycle with `in_valid` held high. A frame of N terms occupies N+1 cycles from `start` to `out_valid`, excluding stalls.
- Handshake on the output side:
  - `out_valid` does not drop until `out_ready` is sampled high.
  - The output transfer and the IDLE entry happen on the same edge.
  - `start` in the cycle after the output transfer is accepted, so back-to-back frames have 1 idle cycle.
- `in_ready` and `out_valid` are registered state decodes. They do not depend combinationally on `in_valid` or `out_ready`.

## Test plan
- Basic sum: `len`=3 with `r_in` = 10, 20, 30 on consecutive cycles → `out_valid` 1 cycle after the third accept, `acc_out`=60, `overflow`=0.
- Gapped input: `len`=4 with `r_in` = 0x00010000 ×4 and `in_valid` low for 2 cycles between beats → `acc_out`=0x40000. Accepts are counted only on valid cycles, and `out_valid` rises exactly 1 cycle after the 4th accept.
- Zero length: `start` with `len`=0 → `out_valid`=1 on the next cycle, `acc_out`=0, `in_ready` never asserts.
- Saturation: `ACC_W`=33, `len`=3, `r_in` = 0xFFFFFFFF ×3 → after beat 2 acc = 0x1FFFFFFFE. After beat 3, `acc_out`=0x1FFFFFFFF and `overflow`=1.
- Backpressure and ignored start:
  - In DONE, hold `out_ready`=0 for 5 cycles and pulse `start` with `len`=7.
  - Required: `out_valid` and `acc_out` stay stable, `in_ready`=0, and the `start` has no effect.
  - After `out_ready`=1: IDLE on the next cycle, and a new `start` is accepted.
- Mid-frame reset: `rst_n`=0 for 1 cycle after 2 of 5 beats → all outputs at their reset values. A following `start` with `len`=1 and `r_in`=5 gives `acc_out`=5, with no residue from the aborted frame.
